// File: rtl/rv_core_pkg.sv
// Shared core definitions: architectural width, canonical NOP, fetch tag.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rv_core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Identity of an outstanding fetch: byte PC it was issued for, plus the
   // epoch it belongs to so returns from before a redirect can be recognised.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            epoch;
   } fetch_tag_t;

   // Byte PCs are always word aligned; low two bits are discarded.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] raw_pc);
      return {raw_pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Small power-of-2 FIFO holding prefetched {instr, pc} entries for decode.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: head holds while pop is low; flush empties it and wins over push.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_dat,
   input  logic                           pop,
   input  logic                           flush,
   output logic                           head_vld,
   output logic [WIDTH-1:0]               head_dat,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop from an empty queue is ignored; a push into a full queue only
   // lands if the head leaves in the same cycle.
   assign do_pop   = pop && (count != '0);
   assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);

   // Head comes straight from storage flops, so nothing downstream of the
   // consumer's ready can reach these outputs.
   assign head_vld = (count != '0);
   assign head_dat = store[rd_ptr];

   // Pointer, occupancy and storage update; flush discards everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr] <= push_dat;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word read per cycle and hands {instr, pc} to decode.
// Latency: issue at cycle 0, memory data at 1, instr_valid at 2 (also after redirect+1).
// Backpressure: fetch stops once queued + in-flight words would exceed the queue.
module instr_fetch_unit
   import rv_core_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 16,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [31:0]           instr_pc
);

   localparam int CW = $clog2(QUEUE_DEPTH+1);

   logic [31:0]            pc;
   logic                   epoch;
   logic                   inflight;
   fetch_tag_t             tag;

   logic [CW-1:0]          q_count;
   logic                   q_head_vld;
   logic [DATA_WIDTH+31:0] q_head_dat;
   logic [DATA_WIDTH+31:0] q_push_dat;
   logic                   pop;
   logic                   issue;
   logic                   ret_ok;
   logic [CW:0]            occupancy;
   logic                   unused_redirect_low;

   // Low bits of the redirect target never matter; words are aligned.
   assign unused_redirect_low = ^redirect_pc[1:0];

   assign mem_address = pc[ADDR_WIDTH+1:2];

   // Decode takes the head this cycle.
   assign pop = q_head_vld && instr_ready;

   // Slots already claimed: queued words plus the read on its way back.
   // A head leaving this cycle frees its slot in time for the next return,
   // which is what lets a two-entry queue stream one word per cycle.
   assign occupancy = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue     = !redirect_valid && (occupancy < (CW+1)'(QUEUE_DEPTH));

   // Keep a returning word only if it was fetched in the current epoch.
   assign ret_ok     = inflight && (tag.epoch == epoch);
   assign q_push_dat = {mem_read_data, tag.pc};

   // PC, epoch and outstanding-read tracking; redirect takes priority over issue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         epoch    <= 1'b0;
         inflight <= 1'b0;
         tag      <= '0;
      end else if (redirect_valid) begin
         pc       <= align_pc(redirect_pc);
         epoch    <= ~epoch;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag.pc    <= pc;
            tag.epoch <= epoch;
            pc        <= pc + 32'd4;
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (DATA_WIDTH + 32)
   ) u_fetch_queue (
      .clock    (clock),
      .reset    (reset),
      .push     (ret_ok),
      .push_dat (q_push_dat),
      .pop      (pop),
      .flush    (redirect_valid),
      .head_vld (q_head_vld),
      .head_dat (q_head_dat),
      .count    (q_count)
   );

   assign instr_valid = q_head_vld;
   assign instr       = q_head_dat[DATA_WIDTH+31:32];
   assign instr_pc    = q_head_dat[31:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a queue-level fetch model.
// Latency: n/a.
// Backpressure: instr_ready driven from directed patterns.
module tb_instr_fetch_unit;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = 32'h0;
   logic          instr_ready = 1'b0;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_read_data;
   logic          instr_valid;
   logic [DW-1:0] instr;
   logic [31:0]   instr_pc;

   logic          rst2 = 1'b1;
   logic [AW-1:0] mem_address2;
   logic [DW-1:0] mem_read_data2;
   logic          instr_valid2;
   logic [DW-1:0] instr2;
   logic [31:0]   instr_pc2;

   logic [DW-1:0] mem [0:65535];

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   // model state
   logic [31:0] q_i[$];
   logic [31:0] q_p[$];
   logic        m_infl = 1'b0;
   logic [31:0] m_infl_pc = 32'h0;
   logic [31:0] m_pc = 32'h0;
   int          m_occ;
   bit          m_pop;

   always #5 clock = ~clock;

   instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_address    (mem_address),
      .mem_read_data  (mem_read_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0003_FFFC), .QUEUE_DEPTH(DEPTH)) dut_wrap (
      .clock          (clock),
      .reset          (rst2),
      .mem_address    (mem_address2),
      .mem_read_data  (mem_read_data2),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .instr_valid    (instr_valid2),
      .instr_ready    (1'b1),
      .instr          (instr2),
      .instr_pc       (instr_pc2)
   );

   // synchronous word memory, one-cycle read latency
   always @(posedge clock) mem_read_data  <= mem[mem_address];
   always @(posedge clock) mem_read_data2 <= mem[mem_address2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a fetch stream is a queue of (word, pc) plus at most one
   // outstanding read; decode may only see words of the current target stream.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         q_i.delete();
         q_p.delete();
         m_infl = 1'b0;
         m_pc   = 32'h0;
      end else begin
         m_pop = (q_i.size() > 0) && instr_ready;
         if (redirect_valid) begin
            q_i.delete();
            q_p.delete();
            m_infl = 1'b0;
            m_pc   = {redirect_pc[31:2], 2'b00};
         end else begin
            m_occ = q_i.size() + int'(m_infl) - int'(m_pop);
            if (m_pop) begin
               void'(q_i.pop_front());
               void'(q_p.pop_front());
            end
            if (m_infl) begin
               q_i.push_back(mem[m_infl_pc[17:2]]);
               q_p.push_back(m_infl_pc);
            end
            if (m_occ < DEPTH) begin
               m_infl    = 1'b1;
               m_infl_pc = m_pc;
               m_pc      = m_pc + 32'd4;
            end else begin
               m_infl = 1'b0;
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clock) begin
      if (cmp_en) begin
         check("m_valid", {31'b0, instr_valid}, {31'b0, (q_i.size() > 0)});
         check("m_addr", {16'b0, mem_address}, {16'b0, m_pc[17:2]});
         if (q_i.size() > 0) begin
            check("m_instr", instr, q_i[0]);
            check("m_pc", instr_pc, q_p[0]);
         end
         if (reset) begin
            check("m_rst_instr", instr, 32'h0);
            check("m_rst_pc", instr_pc, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // leaves the caller just after the edge that starts cycle 0
   task automatic do_reset();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!instr_valid && k < 8) begin
         @(negedge clock);
         k++;
      end
      check(name, {31'b0, instr_valid}, 32'h1);
   endtask

   logic [31:0] pat;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 + i;
      reset = 1'b1;
      rst2  = 1'b1;
      instr_ready = 1'b1;
      tick();
      cmp_en = 1'b1;
      @(negedge clock);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_addr", {16'b0, mem_address}, 32'h0);
      check("rst_instr", instr, 32'h0);

      // 1) first word at cycle 2, then back-to-back
      tick();
      reset = 1'b0;
      @(negedge clock); check("t1_c0_valid", {31'b0, instr_valid}, 32'h0);
                        check("t1_c0_addr", {16'b0, mem_address}, 32'h0);
      @(negedge clock); check("t1_c1_valid", {31'b0, instr_valid}, 32'h0);
                        check("t1_c1_addr", {16'b0, mem_address}, 32'h1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("t1_valid", {31'b0, instr_valid}, 32'h1);
         check("t1_instr", instr, 32'h1000_0000 + c);
         check("t1_pc", instr_pc, 32'(c * 4));
      end

      // 2) back-pressure for 5 cycles from the first valid
      do_reset();
      tick();
      tick();
      instr_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check("t2_hold_instr", instr, 32'h1000_0000);
         check("t2_hold_pc", instr_pc, 32'h0);
         check("t2_hold_addr", {16'b0, mem_address}, 32'h2);
      end
      tick();
      instr_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("t2_rel_valid", {31'b0, instr_valid}, 32'h1);
         check("t2_rel_instr", instr, 32'h1000_0000 + c);
         check("t2_rel_pc", instr_pc, 32'(c * 4));
      end

      // 3) redirect with a word queued and one in flight, decode stalled
      do_reset();
      tick();
      tick();
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h28;
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      wait_valid("t3_seen");
      check("t3_instr", instr, 32'h1000_000A);
      check("t3_pc", instr_pc, 32'h28);

      // 4) redirect in the same cycle as an accepted transfer
      tick();
      check("t4_head_before", instr_pc, 32'h2C);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2B;
      tick();
      redirect_valid = 1'b0;
      @(negedge clock);
      check("t4_flushed", {31'b0, instr_valid}, 32'h0);
      wait_valid("t4_seen");
      check("t4_instr", instr, 32'h1000_000A);
      check("t4_pc", instr_pc, 32'h28);

      // ready pattern with back-to-back redirects, model-checked
      pat = 32'b1011_0010_1110_0001_1101_0110_0111_1001;
      for (int k = 0; k < 32; k++) begin
         tick();
         instr_ready    = pat[k];
         redirect_valid = (k == 12) || (k == 13) || (k == 25);
         redirect_pc    = (k == 12) ? 32'h100 : (k == 13) ? 32'h3D : 32'h7;
      end
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      repeat (4) tick();

      // 5) asynchronous reset between edges
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("t5_valid", {31'b0, instr_valid}, 32'h0);
      check("t5_instr", instr, 32'h0);
      check("t5_pc", instr_pc, 32'h0);
      check("t5_addr", {16'b0, mem_address}, 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clock); check("t5_c0_valid", {31'b0, instr_valid}, 32'h0);
      @(negedge clock);
      @(negedge clock); check("t5_c2_valid", {31'b0, instr_valid}, 32'h1);
                        check("t5_c2_instr", instr, 32'h1000_0000);
                        check("t5_c2_pc", instr_pc, 32'h0);

      // 6) address and PC wrap on the second instance
      @(negedge clock);
      check("t6_rst_addr", {16'b0, mem_address2}, 32'hFFFF);
      check("t6_rst_valid", {31'b0, instr_valid2}, 32'h0);
      tick();
      rst2 = 1'b0;
      @(negedge clock); check("t6_c0_addr", {16'b0, mem_address2}, 32'hFFFF);
      @(negedge clock); check("t6_c1_addr", {16'b0, mem_address2}, 32'h0000);
      @(negedge clock); check("t6_c2_valid", {31'b0, instr_valid2}, 32'h1);
                        check("t6_c2_pc", instr_pc2, 32'h0003_FFFC);
                        check("t6_c2_instr", instr2, 32'h1000_FFFF);
      @(negedge clock); check("t6_c3_pc", instr_pc2, 32'h0004_0000);
                        check("t6_c3_instr", instr2, 32'h1000_0000);

      tick();
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
